pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage ARM64 core. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits, and it supports a halt/drain/resume sequence. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch squash, memory freeze,
// halt/drain/resume, plus saturating stall and flush counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        br_taken,
  input  logic        dmem_start,
  input  logic        dmem_done,
  input  logic        halt_req,
  input  logic        cnt_clr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'd3;

  state_t      r_state;
  logic        r_mem_wait;
  logic [2:0]  r_drain_cnt;
  logic        r_halted;
  logic [31:0] r_stall;
  logic [15:0] r_flush;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_freeze;
  logic w_active;
  logic w_stall_inc;
  logic w_flush_inc;

  // XZR (x31) is never a real destination, so it cannot hazard
  assign w_rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
  assign w_rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
  assign w_load_use = ex_mem_read & (ex_rd != 5'd31)
                    & (w_rs1_hit | w_rs2_hit);

  assign w_freeze = (dmem_start & ~dmem_done)
                  | (r_mem_wait & ~dmem_done);

  assign w_active    = (r_state != S_HALT);
  assign w_stall_inc = w_active
                     & (w_freeze | (~br_taken & w_load_use));
  assign w_flush_inc = w_active & ~w_freeze & br_taken;

  // Prioritised enable/flush generation
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset || r_state == S_HALT) begin
      pc_en = 1'b0;
    end else if (w_freeze) begin
      pc_en = 1'b0;
    end else if (br_taken) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en      = (r_state != S_DRAIN);
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = (r_state == S_DRAIN);
    end
  end

  // Memory wait tracking and halt/drain/resume sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_mem_wait  <= 1'b0;
      r_drain_cnt <= 3'd0;
      r_halted    <= 1'b0;
    end else begin
      if (dmem_done)
        r_mem_wait <= 1'b0;
      else if (dmem_start)
        r_mem_wait <= 1'b1;

      unique case (r_state)
        S_RUN: begin
          if (halt_req && !w_freeze) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= 3'd0;
          end
        end
        S_DRAIN: begin
          if (!halt_req) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 3'd0;
          end else if (w_freeze) begin
            r_drain_cnt <= r_drain_cnt;
          end else if (br_taken || w_load_use) begin
            r_drain_cnt <= 3'd0;
          end else if (r_drain_cnt == DRAIN_LAST) begin
            r_state     <= S_HALT;
            r_drain_cnt <= 3'd0;
            r_halted    <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
          end
        end
        S_HALT: begin
          if (!halt_req) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_RUN;
          r_drain_cnt <= 3'd0;
          r_halted    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= 32'd0;
      r_flush <= 16'd0;
    end else if (cnt_clr) begin
      r_stall <= 32'd0;
      r_flush <= 16'd0;
    end else begin
      if (w_stall_inc && r_stall != 32'hFFFF_FFFF)
        r_stall <= r_stall + 32'd1;
      if (w_flush_inc && r_flush != 16'hFFFF)
        r_flush <= r_flush + 16'd1;
    end
  end

  assign halted       = r_halted;
  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the combinational
// priority logic plus sequences for freeze, drain, halt and counters.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, br_taken;
  logic        dmem_start, dmem_done, halt_req, cnt_clr;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, halted;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic [6:0]  outs;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .br_taken(br_taken), .dmem_start(dmem_start),
    .dmem_done(dmem_done), .halt_req(halt_req),
    .cnt_clr(cnt_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en,
                 memwb_en, ifid_flush, idex_flush};

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] O_RUN = 7'b1111100;
  localparam logic [6:0] O_LU  = 7'b0011101;
  localparam logic [6:0] O_BR  = 7'b1111111;
  localparam logic [6:0] O_DR  = 7'b0111110;
  localparam logic [6:0] O_OFF = 7'b0000000;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       mr;
    logic       br;
    logic [6:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk7(input string nm, input logic [6:0] got,
                      input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hz_idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; br_taken = 0;
    dmem_start = 0; dmem_done = 0;
    cnt_clr = 0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5;
    id_rs2 = 5; id_use_rs2 = 1;
  endtask

  function automatic vec_t mk(string n, logic [4:0] r1, logic [4:0] r2,
                              logic [4:0] rd, logic u1, logic u2,
                              logic mr, logic br, logic [6:0] e);
    vec_t v;
    v.name = n; v.rs1 = r1; v.rs2 = r2; v.rd = rd;
    v.u1 = u1; v.u2 = u2; v.mr = mr; v.br = br; v.exp = e;
    return v;
  endfunction

  vec_t tbl[9];
  logic dr_st[6];
  logic dr_dn[6];
  logic [6:0] dr_exp[6];

  initial begin
    tbl[0] = mk("idle",      0,  0,  0, 0, 0, 0, 0, O_RUN);
    tbl[1] = mk("lu_rs2",    0,  5,  5, 0, 1, 1, 0, O_LU);
    tbl[2] = mk("xzr",       0, 31, 31, 0, 1, 1, 0, O_RUN);
    tbl[3] = mk("lu_rs1",    7,  0,  7, 1, 0, 1, 0, O_LU);
    tbl[4] = mk("rs1_unused",7,  0,  7, 0, 0, 1, 0, O_RUN);
    tbl[5] = mk("not_load",  7,  0,  7, 1, 0, 0, 0, O_RUN);
    tbl[6] = mk("branch",    0,  0,  0, 0, 0, 0, 1, O_BR);
    tbl[7] = mk("br_over_lu",0,  5,  5, 0, 1, 1, 1, O_BR);
    tbl[8] = mk("rs_mismatch",4, 0,  3, 1, 0, 1, 0, O_RUN);

    dr_st  = '{0, 1, 0, 0, 0, 0};
    dr_dn  = '{0, 0, 0, 1, 0, 0};
    dr_exp = '{O_DR, O_OFF, O_OFF, O_DR, O_DR, O_DR};

    reset = 0; halt_req = 0;
    hz_idle();
    br_taken = 1;
    #2;
    chk7("reset_outs", outs, O_OFF);
    chk7("reset_halted", {6'd0, halted}, 7'd0);
    chk32("reset_stall", stall_cycles, 0);
    chk32("reset_flush", {16'd0, flush_count}, 0);
    br_taken = 0;
    tick(); tick();
    reset = 1;
    #1;
    chk7("post_reset", outs, O_RUN);
    tick();

    for (int i = 0; i < 9; i++) begin
      hz_idle();
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      ex_rd = tbl[i].rd;
      id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2;
      ex_mem_read = tbl[i].mr; br_taken = tbl[i].br;
      #1;
      chk7(tbl[i].name, outs, tbl[i].exp);
      tick();
    end
    hz_idle();
    #1;
    chk32("tbl_stall", stall_cycles, 2);
    chk32("tbl_flush", {16'd0, flush_count}, 2);

    cnt_clr = 1; tick(); cnt_clr = 0;
    chk32("clr_stall", stall_cycles, 0);
    chk32("clr_flush", {16'd0, flush_count}, 0);

    // single bubble, then load moves to MEM
    set_lu();
    #1; chk7("lu_cycle", outs, O_LU);
    tick();
    ex_mem_read = 0;
    #1; chk7("lu_after", outs, O_RUN);
    chk32("lu_stall1", stall_cycles, 1);
    tick();

    // branch beats load-use
    set_lu(); br_taken = 1;
    #1; chk7("br_lu", outs, O_BR);
    tick();
    hz_idle();
    #1;
    chk32("br_lu_flush", {16'd0, flush_count}, 1);
    chk32("br_lu_stall", stall_cycles, 1);

    // 3-cycle memory wait
    cnt_clr = 1; tick(); cnt_clr = 0;
    dmem_start = 1;
    #1; chk7("mw_start", outs, O_OFF);
    tick();
    dmem_start = 0;
    for (int i = 0; i < 2; i++) begin
      #1; chk7("mw_wait", outs, O_OFF);
      tick();
    end
    dmem_done = 1;
    #1; chk7("mw_done", outs, O_RUN);
    tick();
    dmem_done = 0;
    #1;
    chk7("mw_after", outs, O_RUN);
    chk32("mw_stall", stall_cycles, 3);
    tick();
    dmem_start = 1; dmem_done = 1;
    #1; chk7("mw_same", outs, O_RUN);
    tick();
    dmem_start = 0; dmem_done = 0;
    #1;
    chk7("mw_same_next", outs, O_RUN);
    chk32("mw_same_stall", stall_cycles, 3);
    tick();

    // halt / drain / resume
    halt_req = 1;
    #1; chk7("halt_run_cycle", outs, O_RUN);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk7("drain_outs", outs, O_DR);
      chk7("drain_halted", {6'd0, halted}, 7'd0);
      tick();
    end
    chk7("halted_set", {6'd0, halted}, 7'd1);
    chk7("halted_outs", outs, O_OFF);
    tick();
    halt_req = 0;
    #1;
    chk7("halted_hold", {6'd0, halted}, 7'd1);
    tick();
    chk7("resume_halted", {6'd0, halted}, 7'd0);
    chk7("resume_outs", outs, O_RUN);
    tick();

    // drain with a 2-cycle freeze
    halt_req = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      dmem_start = dr_st[i]; dmem_done = dr_dn[i];
      #1;
      chk7("drfz_outs", outs, dr_exp[i]);
      chk7("drfz_halted", {6'd0, halted}, 7'd0);
      tick();
    end
    hz_idle();
    #1;
    chk7("drfz_halt", {6'd0, halted}, 7'd1);
    halt_req = 0;
    tick();
    chk7("drfz_resume", {6'd0, halted}, 7'd0);

    // branch mid-drain restarts the drain count
    halt_req = 1;
    tick();
    repeat (3) tick();
    br_taken = 1;
    #1; chk7("drbr_outs", outs, O_BR);
    tick();
    br_taken = 0;
    repeat (3) tick();
    chk7("drbr_not_yet", {6'd0, halted}, 7'd0);
    chk7("drbr_still_dr", outs, O_DR);
    tick();
    chk7("drbr_halt", {6'd0, halted}, 7'd1);
    halt_req = 0;
    tick();

    // halt_req dropped mid-drain
    halt_req = 1;
    tick(); tick();
    halt_req = 0;
    #1; chk7("drop_dr", outs, O_DR);
    tick();
    chk7("drop_run", outs, O_RUN);
    repeat (5) tick();
    chk7("drop_halted", {6'd0, halted}, 7'd0);

    // async reset mid-wait and mid-drain
    dmem_start = 1;
    tick();
    dmem_start = 0;
    halt_req = 1;
    #1; chk7("rst_wait_fz", outs, O_OFF);
    reset = 0;
    #1; chk7("rst_async_outs", outs, O_OFF);
    tick();
    reset = 1;
    #1; chk7("rst_wait_clear", outs, O_RUN);
    tick();
    #1; chk7("rst_dr_entry", outs, O_DR);
    reset = 0;
    #1;
    chk32("rst_cnt", stall_cycles, 0);
    tick();
    reset = 1;
    #1; chk7("rst_dr_run", outs, O_RUN);
    halt_req = 0;
    tick();

    // flush counter saturation and clear priority
    cnt_clr = 1; tick(); cnt_clr = 0;
    br_taken = 1;
    repeat (65535) tick();
    chk32("flush_ffff", {16'd0, flush_count}, 32'h0000FFFF);
    tick();
    chk32("flush_sat", {16'd0, flush_count}, 32'h0000FFFF);
    cnt_clr = 1;
    tick();
    cnt_clr = 0; br_taken = 0;
    chk32("flush_clr", {16'd0, flush_count}, 0);
    set_lu();
    tick();
    chk32("stall_one", stall_cycles, 1);
    cnt_clr = 1;
    tick();
    hz_idle();
    chk32("stall_clr", stall_cycles, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
